// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared core definitions used by the immediate encoder and the immediate
// decoder: the imm_type format codes, the 32-bit instruction word type and a
// small helper for signed-range checks on immediates.
// No ports (package).
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

  // Immediate format codes; 3'b101..3'b111 are not valid formats.
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef logic [31:0] instr_word_t;

  // True when value[31:msb] are all equal, i.e. the value is representable as
  // a sign-extended (msb+1)-bit quantity. An arithmetic shift leaves either all
  // zeros or all ones exactly in that case.
  function automatic logic imm_fits(input logic [31:0] value,
                                    input int unsigned msb);
    logic [31:0] w_upper;
    w_upper = 32'($signed(value) >>> msb);
    return (w_upper == 32'h0000_0000) || (w_upper == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// -----------------------------------------------------------------------------
// imm_pack
// Purely combinational immediate packer. Scatters the immediate bits into the
// positions the core's immediate decoder gathers them from, keeps every other
// bit of the base word, and flags immediates that do not fit their format.
// Ports:
//   i_imm_type  [2:0]  immediate format code (see instr_encoder_pkg)
//   i_imm       [31:0] immediate value to encode
//   i_base_word [31:0] instruction with opcode/register/funct fields
//   o_instr     [31:0] base word with the immediate fields overwritten
//   o_err              immediate out of range or format code invalid
// -----------------------------------------------------------------------------
module imm_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  i_imm_type,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_base_word,
  output logic [31:0] o_instr,
  output logic        o_err
);

  instr_word_t w_word;
  logic        w_err;

  // Start from the base word and overwrite only the immediate fields of the
  // selected format. An unknown format leaves the base word untouched and
  // reports an error. Out-of-range immediates are still packed (truncated).
  always_comb begin
    w_word = i_base_word;
    w_err  = 1'b1;
    case (i_imm_type)
      IMM_I: begin
        w_word[31:20] = i_imm[11:0];
        w_err         = !imm_fits(i_imm, 11);
      end
      IMM_S: begin
        w_word[31:25] = i_imm[11:5];
        w_word[11:7]  = i_imm[4:0];
        w_err         = !imm_fits(i_imm, 11);
      end
      IMM_B: begin
        w_word[31]    = i_imm[12];
        w_word[7]     = i_imm[11];
        w_word[30:25] = i_imm[10:5];
        w_word[11:8]  = i_imm[4:1];
        w_err         = !imm_fits(i_imm, 12) || i_imm[0];
      end
      IMM_U: begin
        w_word[31:12] = i_imm[31:12];
        w_err         = |i_imm[11:0];
      end
      IMM_J: begin
        w_word[31]    = i_imm[20];
        w_word[19:12] = i_imm[19:12];
        w_word[20]    = i_imm[11];
        w_word[30:21] = i_imm[10:1];
        w_err         = !imm_fits(i_imm, 20) || i_imm[0];
      end
      default: begin
      end
    endcase
  end

  assign o_instr = w_word;
  assign o_err   = w_err;

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Two-stage valid/ready pipeline that inserts an immediate into an instruction
// word. S1 registers the request, imm_pack sits between S1 and S2, and S2
// registers the encoded word together with its error flag.
// Ports:
//   clk                 single clock, rising edge
//   rst                 asynchronous active-low reset
//   in_valid / in_ready request handshake
//   imm_type [2:0]      immediate format code
//   imm      [31:0]     immediate value
//   base_word[31:0]     instruction carrying the non-immediate fields
//   out_valid/out_ready result handshake
//   instr    [31:0]     encoded instruction
//   out_err             range error or invalid format for this word
//   err_sticky          set by any delivered word with out_err=1
//   clr_err             clears err_sticky (a simultaneous error delivery wins)
//   enc_cnt  [15:0]     wrapping count of delivered words
// -----------------------------------------------------------------------------
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  imm_type,
  input  logic [31:0] imm,
  input  logic [31:0] base_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        out_err,
  output logic        err_sticky,
  input  logic        clr_err,
  output logic [15:0] enc_cnt
);

  logic        r_rdy_en;
  logic        r_s1_valid;
  logic [2:0]  r_s1_type;
  logic [31:0] r_s1_imm;
  instr_word_t r_s1_base;
  logic        r_s2_valid;
  instr_word_t r_s2_instr;
  logic        r_s2_err;
  logic        r_err_sticky;
  logic [15:0] r_enc_cnt;

  logic        w_s2_load;
  logic        w_accept;
  logic        w_deliver;
  instr_word_t w_pack_instr;
  logic        w_pack_err;

  // S2 can take a new word when it is empty or its word leaves this cycle;
  // S1 may then accept as long as it is empty or draining into S2.
  // r_rdy_en keeps in_ready low during reset and until the first clock edge.
  assign w_s2_load = !r_s2_valid || out_ready;
  assign in_ready  = r_rdy_en && (!r_s1_valid || w_s2_load);
  assign w_accept  = in_valid && in_ready;
  assign w_deliver = r_s2_valid && out_ready;

  // Release request acceptance on the first edge after reset is removed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
    end
  end

  // Stage 1: capture the raw request. When in_ready is high S1 is either empty
  // or handing its word to S2, so its valid simply follows in_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_type  <= '0;
      r_s1_imm   <= '0;
      r_s1_base  <= '0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_accept) begin
        r_s1_type <= imm_type;
        r_s1_imm  <= imm;
        r_s1_base <= base_word;
      end
    end
  end

  imm_pack u_imm_pack (
    .i_imm_type  (r_s1_type),
    .i_imm       (r_s1_imm),
    .i_base_word (r_s1_base),
    .o_instr     (w_pack_instr),
    .o_err       (w_pack_err)
  );

  // Stage 2: register the packed word and its error flag. Data only moves
  // while S2 is loading, so the output holds still under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_s2_instr <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_instr <= w_pack_instr;
        r_s2_err   <= w_pack_err;
      end
    end
  end

  // Delivery bookkeeping: wrapping word counter and a sticky error flag where
  // an erroring delivery takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_enc_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_deliver) begin
        r_enc_cnt <= r_enc_cnt + 16'd1;
      end
      if (w_deliver && r_s2_err) begin
        r_err_sticky <= 1'b1;
      end else if (clr_err) begin
        r_err_sticky <= 1'b0;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign instr      = r_s2_instr;
  assign out_err    = r_s2_err;
  assign err_sticky = r_err_sticky;
  assign enc_cnt    = r_enc_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Self-checking bench for instr_encoder: a table of directed vectors, hand
// sequences for backpressure, reset, counter wrap and sticky-error priority,
// and randomized traffic checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_type;
  logic [31:0] imm;
  logic [31:0] base_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        out_err;
  logic        err_sticky;
  logic        clr_err;
  logic [15:0] enc_cnt;

  instr_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imm_type   (imm_type),
    .imm        (imm),
    .base_word  (base_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr      (instr),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .clr_err    (clr_err),
    .enc_cnt    (enc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errCount   = 0;
  int checkCount = 0;

  // Scoreboard and model state ({err, instr} per accepted request).
  logic [32:0] expQ[$];
  logic [15:0] mCnt    = 16'h0;
  logic        mSticky = 1'b0;
  int          nAcc    = 0;
  int          nDeliv  = 0;

  typedef struct {
    logic [2:0]  immType;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] expInstr;
    logic        expErr;
  } vec_t;

  vec_t vecs[11];

  // Compare one value and report a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference encoding from the format rules, using ranges and masks.
  function automatic logic [32:0] refEncode(input logic [2:0] t,
                                            input logic [31:0] v,
                                            input logic [31:0] b);
    int signed   s;
    logic        e;
    logic [31:0] w;
    s = signed'(v);
    case (t)
      3'd0: begin
        e = (s < -2048) || (s > 2047);
        w = (b & 32'h000FFFFF) | ((v & 32'hFFF) << 20);
      end
      3'd1: begin
        e = (s < -2048) || (s > 2047);
        w = (b & 32'h01FFF07F) | (((v >> 5) & 32'h7F) << 25) | ((v & 32'h1F) << 7);
      end
      3'd2: begin
        e = (s < -4096) || (s > 4095) || ((v % 2) != 0);
        w = (b & 32'h01FFF07F) | (((v >> 12) & 32'h1) << 31) | (((v >> 11) & 32'h1) << 7)
          | (((v >> 5) & 32'h3F) << 25) | (((v >> 1) & 32'hF) << 8);
      end
      3'd3: begin
        e = (v % 4096) != 0;
        w = (b & 32'h00000FFF) | (v & 32'hFFFFF000);
      end
      3'd4: begin
        e = (s < -1048576) || (s > 1048575) || ((v % 2) != 0);
        w = (b & 32'h00000FFF) | (((v >> 20) & 32'h1) << 31) | (((v >> 12) & 32'hFF) << 12)
          | (((v >> 11) & 32'h1) << 20) | (((v >> 1) & 32'h3FF) << 21);
      end
      default: begin
        e = 1'b1;
        w = b;
      end
    endcase
    return {e, w};
  endfunction

  // Monitor: handshakes are stable between the falling edge and the next
  // rising edge, so events for that edge are decided here.
  initial begin
    logic [32:0] e;
    logic        eErr;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (out_valid && out_ready) begin
          checkOutput("encCntAtDelivery", 32'(enc_cnt), 32'(mCnt));
          checkOutput("stickyAtDelivery", 32'(err_sticky), 32'(mSticky));
          checkOutput("wordExpected", 32'(expQ.size() == 0), 32'd0);
          eErr = out_err;
          if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("scoreInstr", instr, e[31:0]);
            checkOutput("scoreOutErr", 32'(out_err), 32'(e[32]));
            eErr = e[32];
          end
          mCnt = mCnt + 16'd1;
          nDeliv++;
          if (eErr) mSticky = 1'b1;
          else if (clr_err) mSticky = 1'b0;
        end else if (clr_err) begin
          mSticky = 1'b0;
        end
        if (in_valid && in_ready) begin
          expQ.push_back(refEncode(imm_type, imm, base_word));
          nAcc++;
        end
      end
    end
  end

  // Asynchronous reset with checks of the reset state and ready release.
  task automatic applyReset();
    in_valid = 1'b0;
    clr_err  = 1'b0;
    rst      = 1'b0;
    #1;
    expQ.delete();
    mCnt    = 16'h0;
    mSticky = 1'b0;
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstEncCnt", 32'(enc_cnt), 32'd0);
    checkOutput("rstInReady", 32'(in_ready), 32'd0);
    checkOutput("rstSticky", 32'(err_sticky), 32'd0);
    checkOutput("rstInstr", instr, 32'd0);
    checkOutput("rstOutErr", 32'(out_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("inReadyBeforeFirstEdge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("inReadyAfterFirstEdge", 32'(in_ready), 32'd1);
  endtask

  // Stop offering and wait (bounded) for the pipeline to empty.
  task automatic waitDrain(input string name);
    in_valid = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (expQ.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    checkOutput(name, 32'(expQ.size()) + 32'(out_valid), 32'd0);
  endtask

  // Single-request offer held until the edge that accepts it.
  task automatic applyStimulus(input logic [2:0] t, input logic [31:0] v,
                               input logic [31:0] b);
    imm_type  = t;
    imm       = v;
    base_word = b;
    in_valid  = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int          k;
    int          startAcc;
    int          startDeliv;
    logic [31:0] r;
    logic [2:0]  t;
    logic [31:0] bp[3];

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_err   = 1'b0;
    imm_type  = 3'd0;
    imm       = 32'd0;
    base_word = 32'd0;

    vecs[0]  = '{IMM_I, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b0};
    vecs[1]  = '{IMM_I, 32'h000007FF, 32'h00000013, 32'h7FF00013, 1'b0};
    vecs[2]  = '{IMM_I, 32'h00000800, 32'h00000013, 32'h80000013, 1'b1};
    vecs[3]  = '{IMM_I, 32'h00000000, 32'hFFFFF013, 32'h000FF013, 1'b0};
    vecs[4]  = '{IMM_S, 32'hFFFFFFFC, 32'h00002023, 32'hFE002E23, 1'b0};
    vecs[5]  = '{IMM_B, 32'h00000800, 32'h00000063, 32'h000000E3, 1'b0};
    vecs[6]  = '{IMM_B, 32'h00000801, 32'h00000063, 32'h000000E3, 1'b1};
    vecs[7]  = '{IMM_U, 32'h12345001, 32'h00000037, 32'h12345037, 1'b1};
    vecs[8]  = '{IMM_J, 32'h00000002, 32'h0000006F, 32'h0020006F, 1'b0};
    vecs[9]  = '{IMM_J, 32'h00100000, 32'h0000006F, 32'h8000006F, 1'b1};
    vecs[10] = '{3'b101, 32'hABCDEF01, 32'h12345678, 32'h12345678, 1'b1};

    @(posedge clk);
    #1;
    applyReset();

    // Directed vectors: accept at edge k, word visible after edge k+1.
    for (int i = 0; i < 11; i++) begin
      imm_type  = vecs[i].immType;
      imm       = vecs[i].imm;
      base_word = vecs[i].base;
      in_valid  = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("vec%0d_inReady", i), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput($sformatf("vec%0d_notYetValid", i), 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_outValid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d_instr", i), instr, vecs[i].expInstr);
      checkOutput($sformatf("vec%0d_outErr", i), 32'(out_err), 32'(vecs[i].expErr));
      @(posedge clk);
      #1;
      if (vecs[i].expErr)
        checkOutput($sformatf("vec%0d_sticky", i), 32'(err_sticky), 32'd1);
    end
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    checkOutput("stickyCleared", 32'(err_sticky), 32'd0);

    // Backpressure: five stalled cycles, three requests offered.
    applyReset();
    bp[0] = 32'd1;
    bp[1] = 32'd2;
    bp[2] = 32'd3;
    startDeliv = nDeliv;
    out_ready  = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      imm_type  = IMM_I;
      imm       = bp[k];
      base_word = 32'h00000013;
      in_valid  = 1'b1;
      @(negedge clk);
      if (in_ready && k < 2) k++;
      @(posedge clk);
      #1;
    end
    checkOutput("bpAccepted", 32'(k), 32'd2);
    checkOutput("bpInReady", 32'(in_ready), 32'd0);
    checkOutput("bpOutValid", 32'(out_valid), 32'd1);
    checkOutput("bpHeldInstr", instr, 32'h00100013);
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (k < 3) begin
        imm      = bp[k];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) k++;
      @(posedge clk);
      #1;
      if (k == 3 && expQ.size() == 0 && !out_valid) break;
    end
    waitDrain("bpDrain");
    checkOutput("bpDelivered", 32'(nDeliv - startDeliv), 32'd3);
    checkOutput("bpEncCnt", 32'(enc_cnt), 32'd3);

    // Reset while words are in flight.
    out_ready = 1'b0;
    imm       = 32'd5;
    in_valid  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("midRstPreValid", 32'(out_valid), 32'd1);
    checkOutput("midRstPreCnt", 32'(enc_cnt), 32'd3);
    applyReset();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midRstNoStale", 32'(out_valid), 32'd0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || (nAcc != startAcc)) begin
        t = 3'($urandom_range(0, 5));
        if (t == 3'd5) t = 3'($urandom_range(5, 7));
        case ($urandom_range(0, 3))
          0: r = $urandom();
          1: r = 32'($urandom_range(0, 10000)) - 32'd5000;
          2: r = 32'($urandom_range(0, 4200000)) - 32'd2100000;
          default: r = $urandom() & 32'hFFFFF000;
        endcase
        if ($urandom_range(0, 1) == 1) r[0] = 1'b0;
        imm_type  = t;
        imm       = r;
        base_word = $urandom();
        in_valid  = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      clr_err   = ($urandom_range(0, 7) == 0);
      startAcc  = nAcc;
      @(posedge clk);
      #1;
    end
    clr_err   = 1'b0;
    out_ready = 1'b1;
    waitDrain("randDrain");

    // Counter wrap: 0xFFFF deliveries, then one more.
    applyReset();
    out_ready = 1'b1;
    imm_type  = IMM_I;
    imm       = 32'd0;
    base_word = 32'h00000013;
    startAcc  = nAcc;
    in_valid  = 1'b1;
    for (int c = 0; c < 70000; c++) begin
      @(posedge clk);
      #1;
      if (nAcc - startAcc >= 65535) break;
    end
    in_valid = 1'b0;
    checkOutput("wrapAccepted", 32'(nAcc - startAcc), 32'd65535);
    waitDrain("wrapDrain");
    checkOutput("cntPreload", 32'(enc_cnt), 32'h0000FFFF);
    applyStimulus(IMM_I, 32'd7, 32'h00000013);
    waitDrain("wrapLastDrain");
    checkOutput("cntWrapped", 32'(enc_cnt), 32'd0);

    // Error delivery and clr_err in the same cycle: set wins.
    checkOutput("stickyBeforePriority", 32'(err_sticky), 32'd0);
    out_ready = 1'b0;
    applyStimulus(3'b110, 32'd0, 32'h00000033);
    @(posedge clk);
    #1;
    checkOutput("priorityWordWaiting", 32'(out_valid), 32'd1);
    clr_err   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    checkOutput("stickySetWins", 32'(err_sticky), 32'd1);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    checkOutput("stickyClearAfter", 32'(err_sticky), 32'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
